// File: rtl/stump_mem_arbiter.sv
// -----------------------------------------------------------------------------
// stump_mem_arbiter
//
// Shares the Stump's single memory port between the CPU and a debug host
// (Perentie-side peek/poke). The CPU owns the port by default; a granted debug
// access takes the port for exactly one cycle (S_DBG) while cpu_hold freezes
// the control block, PC and IR. The following cycle (S_ACK) returns the port to
// the CPU and pulses dbg_ack. A bounded-wait counter lets debug pre-empt a CPU
// that issues back-to-back memory cycles after MAX_WAIT consecutive denials.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   cpu_addr/wdata    CPU address and write data
//   cpu_wen/ren       CPU write/read enables
//   cpu_rdata         read data to CPU (straight from memory)
//   cpu_hold          CPU must not advance this cycle
//   dbg_req/we        debug request (level) and direction (1 = write)
//   dbg_addr/wdata    debug address and write data
//   dbg_halt          debug halt; forces cpu_hold, grants debug immediately
//   dbg_ack           one-cycle completion pulse
//   dbg_rdata         registered debug read data, valid from dbg_ack onward
//   mem_*             memory port (write on clk edge, combinational read)
// -----------------------------------------------------------------------------
module stump_mem_arbiter #(
   parameter int WIDTH    = 16,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   input  logic             cpu_wen,
   input  logic             cpu_ren,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_hold,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [WIDTH-1:0] dbg_addr,
   input  logic [WIDTH-1:0] dbg_wdata,
   input  logic             dbg_halt,
   output logic             dbg_ack,
   output logic [WIDTH-1:0] dbg_rdata,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_wen,
   output logic             mem_ren,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_CPU = 2'd0,
      S_DBG = 2'd1,
      S_ACK = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] addr;
      logic [WIDTH-1:0] wdata;
      logic             wen;
      logic             ren;
   } port_t;

   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_nxt;
   logic             cpu_req;
   logic             grant;
   port_t            cpu_port, dbg_port, mem_port;

   assign cpu_req  = cpu_wen | cpu_ren;
   assign cpu_hold = (state == S_DBG) | dbg_halt;
   assign dbg_ack  = (state == S_ACK);

   // Debug wins when the CPU leaves the port idle, when the CPU is halted
   // anyway, or once it has been starved for MAX_WAIT consecutive cycles.
   // Never granted from S_ACK, so a still-high dbg_req there is ignored.
   assign grant = (state == S_CPU) & dbg_req &
                  (~cpu_req | dbg_halt | (wait_cnt == WAIT_LIM));

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         S_CPU: begin
            if (grant) begin
               state_nxt = S_DBG;
               wait_nxt  = '0;
            end else if (!dbg_req) begin
               wait_nxt  = '0;
            end else if (cpu_req && (wait_cnt != WAIT_LIM)) begin
               // denied this cycle: count towards forced pre-emption
               wait_nxt  = wait_cnt + CNT_W'(1);
            end
         end
         S_DBG:   state_nxt = S_ACK;
         S_ACK:   state_nxt = S_CPU;
         default: state_nxt = S_CPU;
      endcase
   end

   // ------------------------------------------------------------------ registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_CPU;
         wait_cnt  <= '0;
         dbg_rdata <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         // capture on the S_DBG -> S_ACK edge; writes leave the old value
         if ((state == S_DBG) && !dbg_we)
            dbg_rdata <= mem_rdata;
      end
   end

   // ------------------------------------------------------------------ port mux
   always_comb begin
      cpu_port.addr  = cpu_addr;
      cpu_port.wdata = cpu_wdata;
      cpu_port.wen   = cpu_wen & ~cpu_hold;
      cpu_port.ren   = cpu_ren & ~cpu_hold;

      dbg_port.addr  = dbg_addr;
      dbg_port.wdata = dbg_wdata;
      dbg_port.wen   = dbg_we;
      dbg_port.ren   = ~dbg_we;

      mem_port = (state == S_DBG) ? dbg_port : cpu_port;

      // Enables are killed combinationally while reset is asserted so that an
      // access (including an aborted debug write) can never land on the reset
      // edge.
      if (!rst) begin
         mem_port.wen = 1'b0;
         mem_port.ren = 1'b0;
      end
   end

   assign mem_addr  = mem_port.addr;
   assign mem_wdata = mem_port.wdata;
   assign mem_wen   = mem_port.wen;
   assign mem_ren   = mem_port.ren;

   // The CPU ignores this while held, so no muxing is needed.
   assign cpu_rdata = mem_rdata;

endmodule

// File: doc/stump_mem_arbiter.md
Name: stump_mem_arbiter

Overview:
- Shares the Stump's single memory port between the CPU and a debug host (Perentie-side memory peek/poke).
- The CPU owns the port by default. A debug access takes the port for exactly one cycle and asserts cpu_hold, which the control block uses to freeze its state, the PC and the IR.
- A bounded-wait counter guarantees debug forward progress while the CPU issues back-to-back memory cycles.
- Sits between Stump (address/data_out/mem_wen/mem_ren/data_in) and the memory model.

Parameters:
- WIDTH, 16, address and data width.
- MAX_WAIT, 4, number of consecutive denied debug cycles after which debug pre-empts the CPU; 0 means debug always wins.
- CNT_W, 3, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on the rising clk edge).
- cpu_addr  in  WIDTH  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_wen  in  1  CPU write enable.
- cpu_ren  in  1  CPU read enable.
- cpu_rdata  out  WIDTH  read data to CPU.
- cpu_hold  out  1  CPU must not advance this cycle.
- dbg_req  in  1  debug access request (level).
- dbg_we  in  1  1 = write, 0 = read; sampled with dbg_req.
- dbg_addr  in  WIDTH  debug address.
- dbg_wdata  in  WIDTH  debug write data.
- dbg_halt  in  1  debug halt; forces cpu_hold.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  WIDTH  registered read data, valid from dbg_ack onward.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_wen  out  1  memory write enable (write on clk edge).
- mem_ren  out  1  memory read enable.
- mem_rdata  in  WIDTH  memory read data (combinational, same cycle).

Behaviour:
- States:
  - S_CPU: port owned by CPU.
  - S_DBG: port owned by debug.
  - S_ACK: port owned by CPU, dbg_ack=1.
- Reset (rst==0 at an edge): state=S_CPU, wait_cnt=0, dbg_ack=0, dbg_rdata=0. While rst==0, mem_wen=0 and mem_ren=0 combinationally, so no write lands on the reset edge, including when reset arrives during S_DBG.
- Reset during S_DBG aborts the access; no dbg_ack is issued.
- cpu_req = cpu_wen | cpu_ren.
- Port mux (combinational):
  - S_DBG: mem_* = dbg_addr/dbg_wdata, mem_wen=dbg_we, mem_ren=~dbg_we.
  - Otherwise: mem_* = cpu_*, but mem_wen/mem_ren are forced 0 while cpu_hold=1.
- cpu_rdata = mem_rdata always; the CPU ignores it while held.
- cpu_hold = (state==S_DBG) | dbg_halt.
- Transitions:
  - S_CPU -> S_DBG when dbg_req & (~cpu_req | dbg_halt | wait_cnt==MAX_WAIT); otherwise stay in S_CPU.
  - S_DBG -> S_ACK unconditionally after 1 cycle. At that edge dbg_rdata <= mem_rdata for reads; dbg_rdata is unchanged for writes.
  - S_ACK -> S_CPU unconditionally. dbg_req is not granted while in S_ACK.
- Debug handshake:
  - dbg_req is held with stable dbg_we/addr/wdata until dbg_ack.
  - The host drops dbg_req in the cycle after dbg_ack.
  - If dbg_req is still high in the S_CPU cycle after S_ACK, it is a new request.
- Latency: with an idle CPU, dbg_req rising in cycle N gives S_DBG in N+1 and dbg_ack in N+2.
- wait_cnt:
  - In S_CPU with dbg_req & cpu_req & no grant: increments, saturating at MAX_WAIT.
  - Cleared on the transition to S_DBG.
  - Cleared in S_CPU when dbg_req==0.
- The CPU access in the cycle that decides the grant completes normally. The CPU loses only the S_DBG cycle.
- dbg_halt:
  - Level signal; cpu_hold=1 in every state while asserted, and CPU memory enables are gated.
  - Pending debug requests are granted without waiting.
  - Deassertion releases the CPU the next cycle, unless the arbiter is in S_DBG.
- Simultaneous CPU write and debug pre-emption: the CPU write in the deciding cycle is performed. The debug access follows in the next cycle and observes the CPU write.

Test Plan:
- Reset: hold rst=0 for 2 cycles with cpu_wen=1 and dbg_req=1 -> mem_wen=0, dbg_ack=0, cpu_hold=0. After release, state=S_CPU and the CPU write to 0x0010 reaches memory.
- Idle CPU, debug read of 0x0020 (mem holds 0xBEEF) -> mem_addr=0x0020 and cpu_hold=1 exactly one cycle later. dbg_ack pulses in the following cycle with dbg_rdata=0xBEEF.
- CPU reads every cycle, dbg_req held with MAX_WAIT=4 -> 4 denied cycles (wait_cnt 1..4), S_DBG on the 6th cycle, one cpu_hold cycle, dbg_ack, then CPU resumes.
- Debug write 0x1234 to 0x0030 in the cycle after a CPU write of 0x5555 to 0x0030 -> memory ends at 0x1234. A subsequent debug read returns 0x1234.
- dbg_halt=1 with CPU requesting -> cpu_hold=1 and mem_wen/mem_ren=0 every cycle. A debug read is granted in the next cycle without wait. Drop dbg_halt -> CPU accesses resume the cycle after.
- rst=0 asserted during S_DBG with dbg_we=1 -> no memory write occurs, no dbg_ack is issued, wait_cnt=0 afterwards.
